// File: rtl/range_counter.sv
// range_counter: WIDTH-bit counter with programmable step and runtime
// bounds [lo, hi]. Boundary modes: wrap, saturate, bounce. Provides a
// registered terminal-count pulse and a sticky overflow flag.
// Optional feature macro: RANGE_COUNTER_SEQ_TABLE_EN adds a programmable
// next-state table used by mode 11. Without it, mode 11 behaves as wrap.
module range_counter #(
    parameter int WIDTH   = 4,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             hold,
    input  logic             up,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [1:0]       mode,
    input  logic             ovf_clr,
`ifdef RANGE_COUNTER_SEQ_TABLE_EN
    input  logic             tbl_we,
    input  logic [WIDTH-1:0] tbl_addr,
    input  logic [WIDTH-1:0] tbl_data,
`endif
    output logic [WIDTH-1:0] q,
    output logic             dir,
    output logic             tc,
    output logic             ovf,
    output logic             cfg_err
);

    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

    localparam logic [1:0] MODE_WRAP   = 2'b00;
    localparam logic [1:0] MODE_SAT    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_SEQ    = 2'b11;

    logic [WIDTH:0]   up_raw;
    logic [WIDTH:0]   down_raw;
    logic             count_up;
    logic             limit_hit;
    logic             seq_active;
    logic [WIDTH-1:0] seq_next;
    logic [WIDTH-1:0] q_next;
    logic             dir_next;
    logic             tc_next;
    logic             ovf_set;

`ifdef RANGE_COUNTER_SEQ_TABLE_EN
    localparam int DEPTH = 2 ** WIDTH;

    logic [WIDTH-1:0] tbl [DEPTH];

    // Next-state table: reset to the plain ring i -> i+1, writable any cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= WIDTH'(i + 1);
            end
        end else if (tbl_we) begin
            tbl[tbl_addr] <= tbl_data;
        end
    end

    assign seq_active = (mode == MODE_SEQ);
    assign seq_next   = tbl[q];
`else
    assign seq_active = 1'b0;
    assign seq_next   = q;
`endif

    // Raw arithmetic one bit wider than q so carries and borrows are visible
    always_comb begin
        cfg_err   = (lo > hi);
        up_raw    = {1'b0, q} + {1'b0, step};
        down_raw  = {1'b0, q} - {1'b0, step};
        count_up  = (mode == MODE_BOUNCE) ? dir : up;
        limit_hit = 1'b0;
        if (step != '0) begin
            if (count_up) begin
                limit_hit = (up_raw > {1'b0, hi});
            end else begin
                limit_hit = down_raw[WIDTH] || (down_raw[WIDTH-1:0] < lo);
            end
        end
    end

    // Next-state selection in priority order clr > load > hold/cfg_err > count
    always_comb begin
        q_next   = q;
        dir_next = dir;
        tc_next  = 1'b0;
        ovf_set  = 1'b0;
        if (clr) begin
            q_next   = RST_Q;
            dir_next = up;
        end else if (load) begin
            q_next   = d;
            dir_next = up;
        end else if (hold || cfg_err) begin
            q_next   = q;
        end else if (seq_active) begin
            q_next   = seq_next;
            tc_next  = (seq_next == lo);
            ovf_set  = (seq_next == lo);
        end else begin
            dir_next = count_up;
            if (limit_hit) begin
                tc_next = 1'b1;
                ovf_set = 1'b1;
                case (mode)
                    MODE_SAT: begin
                        q_next = count_up ? hi : lo;
                    end
                    MODE_BOUNCE: begin
                        q_next   = count_up ? hi : lo;
                        dir_next = ~count_up;
                    end
                    default: begin
                        q_next = count_up ? lo : hi;
                    end
                endcase
            end else begin
                q_next = count_up ? up_raw[WIDTH-1:0] : down_raw[WIDTH-1:0];
            end
        end
    end

    // Count, direction, terminal count and sticky overflow registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= RST_Q;
            dir <= 1'b1;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            q   <= q_next;
            dir <= dir_next;
            tc  <= tc_next;
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_range_counter.sv
// tb_range_counter: directed self-checking bench for range_counter
// (WIDTH=4, RST_VAL=0). Follows RANGE_COUNTER_SEQ_TABLE_EN for the
// sequence-mode vectors.
module tb_range_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] d = '0;
    logic       hold = 1'b0;
    logic       up = 1'b1;
    logic [3:0] step = '0;
    logic [3:0] lo = '0;
    logic [3:0] hi = '0;
    logic [1:0] mode = '0;
    logic       ovf_clr = 1'b0;
`ifdef RANGE_COUNTER_SEQ_TABLE_EN
    logic       tbl_we = 1'b0;
    logic [3:0] tbl_addr = '0;
    logic [3:0] tbl_data = '0;
`endif
    logic [3:0] q;
    logic       dir;
    logic       tc;
    logic       ovf;
    logic       cfg_err;

    int checkCount = 0;
    int errorCount = 0;

    range_counter #(.WIDTH(4), .RST_VAL(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .load     (load),
        .d        (d),
        .hold     (hold),
        .up       (up),
        .step     (step),
        .lo       (lo),
        .hi       (hi),
        .mode     (mode),
        .ovf_clr  (ovf_clr),
`ifdef RANGE_COUNTER_SEQ_TABLE_EN
        .tbl_we   (tbl_we),
        .tbl_addr (tbl_addr),
        .tbl_data (tbl_data),
`endif
        .q        (q),
        .dir      (dir),
        .tc       (tc),
        .ovf      (ovf),
        .cfg_err  (cfg_err)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive the per-cycle controls, then advance one clock edge
    task automatic applyStimulus(input logic c, input logic l, input logic h,
                                 input logic [3:0] dv, input logic oc);
        clr     = c;
        load    = l;
        hold    = h;
        d       = dv;
        ovf_clr = oc;
        tick();
    endtask

    task automatic countOnce;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        $display("[TB] range_counter directed test start");

        // Asynchronous reset before the first clock edge
        #1 rst = 1'b1;
        #2;
        checkOutput("reset_q", 32'(q), 32'd0);
        checkOutput("reset_dir", 32'(dir), 32'd1);
        checkOutput("reset_tc", 32'(tc), 32'd0);
        checkOutput("reset_ovf", 32'(ovf), 32'd0);
        checkOutput("reset_cfg_err", 32'(cfg_err), 32'd0);
        tick();
        rst = 1'b0;

        // Wrap up: 2 -> 5 -> 8 -> 2 (event) -> 5
        lo = 4'd2; hi = 4'd9; step = 4'd3; mode = 2'b00; up = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd2, 1'b0);
        checkOutput("wrap_load_q", 32'(q), 32'd2);
        countOnce();
        checkOutput("wrap_q5", 32'(q), 32'd5);
        countOnce();
        checkOutput("wrap_q8", 32'(q), 32'd8);
        checkOutput("wrap_q8_tc", 32'(tc), 32'd0);
        countOnce();
        checkOutput("wrap_q2", 32'(q), 32'd2);
        checkOutput("wrap_q2_tc", 32'(tc), 32'd1);
        checkOutput("wrap_q2_ovf", 32'(ovf), 32'd1);
        countOnce();
        checkOutput("wrap_q5b", 32'(q), 32'd5);
        checkOutput("wrap_q5b_tc", 32'(tc), 32'd0);
        checkOutput("wrap_ovf_sticky", 32'(ovf), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        checkOutput("wrap_ovf_clr", 32'(ovf), 32'd0);
        checkOutput("wrap_q8b", 32'(q), 32'd8);

        // Saturate up: load 8 -> 9 (event) -> 9 (event again) -> hold
        mode = 2'b01;
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd8, 1'b0);
        countOnce();
        checkOutput("sat_q9", 32'(q), 32'd9);
        checkOutput("sat_q9_tc", 32'(tc), 32'd1);
        countOnce();
        checkOutput("sat_pinned_q", 32'(q), 32'd9);
        checkOutput("sat_pinned_tc", 32'(tc), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        checkOutput("sat_hold_q", 32'(q), 32'd9);
        checkOutput("sat_hold_tc", 32'(tc), 32'd0);

        // Bounce: load 8 -> 9 (turn) -> 6 -> 3 -> 2 (turn) -> 5
        mode = 2'b10; up = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd8, 1'b0);
        checkOutput("bnc_load_dir", 32'(dir), 32'd1);
        countOnce();
        checkOutput("bnc_q9", 32'(q), 32'd9);
        checkOutput("bnc_q9_dir", 32'(dir), 32'd0);
        checkOutput("bnc_q9_tc", 32'(tc), 32'd1);
        countOnce();
        checkOutput("bnc_q6", 32'(q), 32'd6);
        checkOutput("bnc_q6_tc", 32'(tc), 32'd0);
        countOnce();
        checkOutput("bnc_q3", 32'(q), 32'd3);
        countOnce();
        checkOutput("bnc_q2", 32'(q), 32'd2);
        checkOutput("bnc_q2_dir", 32'(dir), 32'd1);
        checkOutput("bnc_q2_tc", 32'(tc), 32'd1);
        countOnce();
        checkOutput("bnc_q5", 32'(q), 32'd5);
        checkOutput("bnc_q5_dir", 32'(dir), 32'd1);

        // Priority: clr beats load and hold; load beats hold
        mode = 2'b00;
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd7, 1'b0);
        checkOutput("prio_clr_q", 32'(q), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd7, 1'b0);
        checkOutput("prio_load_q", 32'(q), 32'd7);

        // Inverted bounds freeze the counter
        lo = 4'd9; hi = 4'd2;
        #1;
        checkOutput("cfg_err_set", 32'(cfg_err), 32'd1);
        countOnce();
        checkOutput("cfg_err_frozen_q", 32'(q), 32'd7);
        checkOutput("cfg_err_tc", 32'(tc), 32'd0);
        lo = 4'd2; hi = 4'd9;
        #1;
        checkOutput("cfg_err_clear", 32'(cfg_err), 32'd0);

        // Count to an event, then assert rst between clock edges
        countOnce();
        checkOutput("pre_rst_q", 32'(q), 32'd2);
        checkOutput("pre_rst_ovf", 32'(ovf), 32'd1);
        up = 1'b0;
        countOnce();
        checkOutput("pre_rst_dir", 32'(dir), 32'd0);
        #3 rst = 1'b1;
        #1;
        checkOutput("rst_async_q", 32'(q), 32'd0);
        checkOutput("rst_async_dir", 32'(dir), 32'd1);
        checkOutput("rst_async_ovf", 32'(ovf), 32'd0);
        tick();
        rst = 1'b0;

        // Down with borrow: 1 - 3 wraps to hi with an event
        lo = 4'd0; hi = 4'd15; step = 4'd3; mode = 2'b00; up = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd1, 1'b0);
        checkOutput("down_load_dir", 32'(dir), 32'd0);
        countOnce();
        checkOutput("down_borrow_q", 32'(q), 32'd15);
        checkOutput("down_borrow_tc", 32'(tc), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        checkOutput("down_q12", 32'(q), 32'd12);
        checkOutput("down_ovf_cleared", 32'(ovf), 32'd0);
        for (int i = 0; i < 4; i++) begin
            countOnce();
        end
        checkOutput("down_q0", 32'(q), 32'd0);
        checkOutput("down_q0_tc", 32'(tc), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        checkOutput("down_set_wins_q", 32'(q), 32'd15);
        checkOutput("down_set_wins_ovf", 32'(ovf), 32'd1);

        // Zero step leaves q alone with no event
        step = 4'd0;
        countOnce();
        checkOutput("step0_q", 32'(q), 32'd15);
        checkOutput("step0_tc", 32'(tc), 32'd0);

        // Sequence mode vectors
        step = 4'd3; lo = 4'd5; hi = 4'd9; up = 1'b1;
`ifdef RANGE_COUNTER_SEQ_TABLE_EN
        hold = 1'b1;
        tbl_we = 1'b1;
        tbl_addr = 4'd5; tbl_data = 4'd6; tick();
        tbl_addr = 4'd6; tbl_data = 4'd2; tick();
        tbl_addr = 4'd2; tbl_data = 4'd5; tick();
        tbl_we = 1'b0;
        checkOutput("seq_hold_q", 32'(q), 32'd15);
        mode = 2'b11;
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd5, 1'b1);
        checkOutput("seq_load_ovf", 32'(ovf), 32'd0);
        countOnce();
        checkOutput("seq_q6", 32'(q), 32'd6);
        checkOutput("seq_q6_tc", 32'(tc), 32'd0);
        countOnce();
        checkOutput("seq_q2", 32'(q), 32'd2);
        countOnce();
        checkOutput("seq_q5", 32'(q), 32'd5);
        checkOutput("seq_q5_tc", 32'(tc), 32'd1);
        checkOutput("seq_q5_ovf", 32'(ovf), 32'd1);
        countOnce();
        checkOutput("seq_q6b", 32'(q), 32'd6);
        checkOutput("seq_dir", 32'(dir), 32'd1);
`else
        mode = 2'b11;
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd5, 1'b1);
        checkOutput("seq_load_ovf", 32'(ovf), 32'd0);
        countOnce();
        checkOutput("seq_wrap_q8", 32'(q), 32'd8);
        checkOutput("seq_wrap_q8_tc", 32'(tc), 32'd0);
        countOnce();
        checkOutput("seq_wrap_q5", 32'(q), 32'd5);
        checkOutput("seq_wrap_q5_tc", 32'(tc), 32'd1);
        checkOutput("seq_wrap_q5_ovf", 32'(ovf), 32'd1);
        countOnce();
        checkOutput("seq_wrap_q8b", 32'(q), 32'd8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
